v_reservation_tracker: RTL
==========================

# v_reservation_tracker

Tracks reservations on the eight vector registers and eight vector functional units, downstream of the vector issue scheduler. Consumes the scheduler's one-cycle start strobes, functional-unit delay and the current vector length. Produces the registered `busy`, `chain_n` and functional-unit `busy` vectors that the scheduler's ready logic samples on the next cycle. The block implements Cray-style chain-slot timing, so a dependent instruction can issue exactly when element 0 of a result is written.

## Interface
Parameters:
- `LOGDEPTH`, 6: log2 of the vector register depth. VL is `LOGDEPTH+1` bits wide.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `i_vwrite_start`  in  8  one-hot strobe; Vi write reservation starts.
- `i_vread_start`  in  8  strobe, up to two bits set (Vj, Vk); read reservation starts.
- `i_vfu_start`  in  8  one-hot strobe; functional unit reservation starts.
- `i_fu_delay`  in  4  functional unit latency D, in cycles, for this issue.
- `i_vl`  in  LOGDEPTH+1  vector length. A value of 0 is treated as 2^LOGDEPTH (64).
- `o_vreg_busy`  out  8  per-register reservation active.
- `o_vreg_chain_n`  out  8  per-register chain slot, active-low.
- `o_vfu_busy`  out  8  per-functional-unit reservation active.

## Operation
- Each register has its own FSM with states IDLE, WR_WAIT, WR_CHAIN, WR_STREAM and RD, plus a 7-bit down-counter.
- **Write start on register r:**
  - Deff = max(D, 1).
  - If Deff > 1: enter WR_WAIT with count = Deff−1. Otherwise go directly to WR_CHAIN.
  - WR_WAIT decrements each cycle and moves to WR_CHAIN when the count reaches 1.
  - WR_CHAIN lasts 1 cycle. It then moves to WR_STREAM with count = VL−1, or to IDLE if VL = 1.
  - WR_STREAM decrements each cycle and moves to IDLE when the count reaches 1.
- **Read start on register r:**
  - From IDLE, enter RD with count = VL; RD decrements each cycle and moves to IDLE when the count reaches 1.
  - If r is in any WR_* state, the read strobe is ignored. This is the chained read, which trails the writes.
- **Write and read strobe on the same register in the same cycle:** the write wins.
- **Any strobe to a register already in RD:** restarts with the new reservation (overwrite). This is legal only as a recovery path.
- **Outputs:**
  - `o_vreg_busy[r]` = state ≠ IDLE.
  - `o_vreg_chain_n[r]` = 0 only in WR_CHAIN.
- **Functional units:** each has a counter. A strobe loads VL. `o_vfu_busy` = count ≠ 0. The counter decrements each cycle. A strobe while busy reloads the counter.
- VL and D are sampled only in the strobe cycle. Later changes do not affect reservations already in progress.
- All outputs come directly from flops; there is no combinational path from input to output.

## Timing
- **Reset (`rst_n` = 0 at an edge):** all FSMs go to IDLE and all counters clear. `o_vreg_busy` = 8'h00, `o_vreg_chain_n` = 8'hFF, `o_vfu_busy` = 8'h00. Reset has priority over strobes in the same cycle. Reset mid-reservation aborts it immediately.
- **Write strobe sampled at edge T:**
  - `busy` is high for cycles T+1 through T+Deff+VL−1, i.e. Deff+VL−1 cycles in total.
  - `chain_n` is low only in cycle T+Deff.
- **Read strobe at T:** `busy` is high for cycles T+1 through T+VL.
- **Functional-unit strobe at T:** `o_vfu_busy` is high for cycles T+1 through T+VL.
- **VL = 1:** the chain slot is also the last busy cycle.

## Configuration
- `VREG_CHAIN_EN` defined: chain-slot behaviour as described above.
- Not defined:
  - WR_CHAIN still exists for timing purposes.
  - `o_vreg_chain_n` is tied to 8'hFF, so no chaining occurs.
  - The scheduler therefore waits for full write completion.

## Test plan
- **Reset values:** assert `rst_n` low for 2 cycles while strobes are active. Every cycle shows busy 00, chain_n FF, vfu_busy 00.
- **Write timing:** write strobe on V3 at T with D = 4, VL = 8. `busy[3]` is high for T+1..T+11. `chain_n[3]` is low only at T+4. `vfu_busy` is high for T+1..T+8.
- **Degenerate case:** D = 0, VL = 1 on V0. `busy[0]` is high only at T+1. `chain_n[0]` is low at T+1.
- **Combined reads and chained read:**
  - Read strobe on V1 and V2 at T with VL = 0. Both are busy for 64 cycles, T+1..T+64.
  - A read strobe on V5 during its WR_CHAIN cycle leaves the write busy window unchanged.
- **Write wins:** write and read strobes on V6 in the same cycle with D = 2, VL = 4. `busy[6]` is high for T+1..T+5, following the write rule.
- **Reset abort:** pull `rst_n` low mid-WR_STREAM. All outputs return to their reset values at the next edge. Repeat with `VREG_CHAIN_EN` undefined; `chain_n` stays at FF throughout.

Source files
------------

// File: rtl/v_reservation_tracker.sv
// Vector register / functional-unit reservation tracker with Cray-style chain-slot timing.
// Optional macro VREG_CHAIN_EN enables the active-low chain-slot output; otherwise it is held at all ones.
module v_reservation_tracker #(
    parameter int LOGDEPTH = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          i_vwrite_start,
    input  logic [7:0]          i_vread_start,
    input  logic [7:0]          i_vfu_start,
    input  logic [3:0]          i_fu_delay,
    input  logic [LOGDEPTH:0]   i_vl,
    output logic [7:0]          o_vreg_busy,
    output logic [7:0]          o_vreg_chain_n,
    output logic [7:0]          o_vfu_busy
);

    // Counter must hold both a full vector length and the largest wait (D-1 = 14).
    localparam int CW = (LOGDEPTH + 1 > 4) ? LOGDEPTH + 1 : 4;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_CHAIN,
        WR_STREAM,
        RD
    } vreg_state_t;

    logic [CW-1:0] vl_eff;
    logic [3:0]    deff;
    logic [CW-1:0] wait_load;

    always_comb begin
        vl_eff    = (i_vl == '0) ? CW'(1 << LOGDEPTH) : CW'(i_vl);
        deff      = (i_fu_delay == 4'd0) ? 4'd1 : i_fu_delay;
        wait_load = CW'(deff - 4'd1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_vreg
            vreg_state_t   state_reg, state_next;
            logic [CW-1:0] cnt_reg, cnt_next;
            logic [CW-1:0] vlen_reg, vlen_next;
            logic          busy_reg, chain_n_reg;

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                vlen_next  = vlen_reg;
                case (state_reg)
                    WR_WAIT: begin
                        if (cnt_reg == CW'(1)) begin
                            state_next = WR_CHAIN;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg - CW'(1);
                        end
                    end
                    WR_CHAIN: begin
                        if (vlen_reg == CW'(1)) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            state_next = WR_STREAM;
                            cnt_next   = vlen_reg - CW'(1);
                        end
                    end
                    WR_STREAM, RD: begin
                        if (cnt_reg == CW'(1)) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg - CW'(1);
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                endcase

                // Write beats read; a read arriving during a write is the chained read and is dropped.
                if (i_vwrite_start[gi]) begin
                    vlen_next = vl_eff;
                    if (deff > 4'd1) begin
                        state_next = WR_WAIT;
                        cnt_next   = wait_load;
                    end else begin
                        state_next = WR_CHAIN;
                        cnt_next   = '0;
                    end
                end else if (i_vread_start[gi] && (state_reg == IDLE || state_reg == RD)) begin
                    state_next = RD;
                    cnt_next   = vl_eff;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_reg   <= IDLE;
                    cnt_reg     <= '0;
                    vlen_reg    <= '0;
                    busy_reg    <= 1'b0;
                    chain_n_reg <= 1'b1;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    vlen_reg  <= vlen_next;
                    busy_reg  <= (state_next != IDLE);
`ifdef VREG_CHAIN_EN
                    chain_n_reg <= (state_next != WR_CHAIN);
`else
                    chain_n_reg <= 1'b1;
`endif
                end
            end

            assign o_vreg_busy[gi]    = busy_reg;
            assign o_vreg_chain_n[gi] = chain_n_reg;
        end

        for (gi = 0; gi < 8; gi++) begin : g_vfu
            logic [CW-1:0] cnt_reg, cnt_next;
            logic          busy_reg;

            always_comb begin
                if (i_vfu_start[gi])
                    cnt_next = vl_eff;
                else if (cnt_reg != '0)
                    cnt_next = cnt_reg - CW'(1);
                else
                    cnt_next = '0;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg  <= '0;
                    busy_reg <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    busy_reg <= (cnt_next != '0);
                end
            end

            assign o_vfu_busy[gi] = busy_reg;
        end
    endgenerate

endmodule
